// File: rtl/qnigma_fifo_pkg.sv
// rtl/qnigma_fifo_pkg.sv - shared constants and helpers for the qnigma FIFO controller
package qnigma_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/qnigma_fifo_skid.sv
// rtl/qnigma_fifo_skid.sv - 2-entry register FIFO absorbing the RAM read latency
module qnigma_fifo_skid
  import qnigma_fifo_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [DW-1:0]      push_dat_i,
  input  logic               pop_i,
  output logic [SKID_CW-1:0] cnt_o,
  output logic [DW-1:0]      head_o
);

  logic [DW-1:0]      head_q, head_d;
  logic [DW-1:0]      tail_q, tail_d;
  logic [SKID_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + {{(SKID_CW-1){1'b0}}, push_i} - {{(SKID_CW-1){1'b0}}, pop_i};
    if (pop_i) head_d = tail_q;
    // The pushed word lands in whichever slot is first free after this cycle's pop.
    if (push_i) begin
      if (cnt_q == {{(SKID_CW-1){1'b0}}, pop_i}) head_d = push_dat_i;
      else                                       tail_d = push_dat_i;
    end
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = head_q;

endmodule

// File: rtl/qnigma_fifo_ctrl.sv
// rtl/qnigma_fifo_ctrl.sv - FWFT FIFO controller over a dual-port RAM
// Optional almost-full/almost-empty flags: QNIGMA_FIFO_FLAGS_EN.
module qnigma_fifo_ctrl
  import qnigma_fifo_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
`ifdef QNIGMA_FIFO_FLAGS_EN
  ,
  parameter int AFULL  = 2**AW - 4,
  parameter int AEMPTY = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DW-1:0]        in_dat,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [DW-1:0]        out_dat,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [lvl_w(AW)-1:0] level,
  output logic [DW-1:0]        ram_d_a,
  output logic [AW-1:0]        ram_a_a,
  output logic                 ram_w_a,
  output logic [AW-1:0]        ram_a_b,
  output logic                 ram_w_b,
  input  logic [DW-1:0]        ram_q_b
`ifdef QNIGMA_FIFO_FLAGS_EN
  ,
  output logic                 afull,
  output logic                 aempty
`endif
);

  localparam int                LW      = lvl_w(AW);
  localparam logic [LW-1:0]     CAP     = {1'b1, {AW{1'b0}}};
  localparam logic [SKID_CW:0]  OCC_MAX = (SKID_CW+1)'(SKID_DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               rd_pend_q, rd_pend_d;
  logic [SKID_CW-1:0] skid_cnt;
  logic [SKID_CW:0]   occ;
  logic               wr_acc, pop, issue;

  assign in_rdy  = ~rst & ~flush & (level_q != CAP);
  assign wr_acc  = in_val & in_rdy;
  assign out_val = (skid_cnt != '0);
  assign pop     = out_val & out_rdy & ~flush;

  // Skid slots already spoken for; a same-cycle pop frees one for a new issue.
  assign occ   = {1'b0, skid_cnt} + {{SKID_CW{1'b0}}, rd_pend_q};
  assign issue = (wr_ptr_q != rd_ptr_q) & ((occ < OCC_MAX) | ((occ == OCC_MAX) & pop));

  assign ram_w_a = wr_acc;
  assign ram_a_a = wr_ptr_q[AW-1:0];
  assign ram_d_a = in_dat;
  assign ram_a_b = rd_ptr_q[AW-1:0];
  assign ram_w_b = 1'b0;
  assign level   = level_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_acc};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, issue};
    rd_pend_d = issue;
    level_d   = level_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, pop};
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_pend_d = 1'b0;
      level_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
      level_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pend_q <= rd_pend_d;
      level_q   <= level_d;
    end
  end

  qnigma_fifo_skid #(.DW(DW)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .push_i     (rd_pend_q & ~flush),
    .push_dat_i (ram_q_b),
    .pop_i      (pop),
    .cnt_o      (skid_cnt),
    .head_o     (out_dat)
  );

`ifdef QNIGMA_FIFO_FLAGS_EN
  logic afull_q, aempty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else if (flush) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= (level_q >= LW'(AFULL));
      aempty_q <= (level_q <= LW'(AEMPTY));
    end
  end

  assign afull  = afull_q;
  assign aempty = aempty_q;
`endif

endmodule

// File: tb/tb_qnigma_fifo_ctrl.sv
// tb/tb_qnigma_fifo_ctrl.sv - scoreboard bench for qnigma_fifo_ctrl with AW=3
module tb_qnigma_fifo_ctrl;
  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int CAP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] in_dat = '0;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] out_dat;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [AW:0]   level;
  logic [DW-1:0] ram_d_a;
  logic [AW-1:0] ram_a_a;
  logic          ram_w_a;
  logic [AW-1:0] ram_a_b;
  logic          ram_w_b;
  logic [DW-1:0] ram_q_b;
`ifdef QNIGMA_FIFO_FLAGS_EN
  logic          afull;
  logic          aempty;
`endif

  logic [DW-1:0] ram [CAP];
  logic [DW-1:0] exp_q[$];
  int            cnt_m = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  qnigma_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_dat  (in_dat),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .out_dat (out_dat),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .level   (level),
    .ram_d_a (ram_d_a),
    .ram_a_a (ram_a_a),
    .ram_w_a (ram_w_a),
    .ram_a_b (ram_a_b),
    .ram_w_b (ram_w_b),
    .ram_q_b (ram_q_b)
`ifdef QNIGMA_FIFO_FLAGS_EN
    ,
    .afull   (afull),
    .aempty  (aempty)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_w_a) ram[ram_a_a] <= ram_d_a;
    ram_q_b <= ram[ram_a_b];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: words held and acceptance rule, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cnt_m = 0;
    end else begin
      chk("model_level", int'(level), cnt_m);
      chk("model_in_rdy", int'(in_rdy), int'(!flush && cnt_m != CAP));
      chk("level_bound", int'(level <= CAP), 1);
      if (flush) begin
        exp_q.delete();
        cnt_m = 0;
      end else begin
        if (in_val && in_rdy) begin
          exp_q.push_back(in_dat);
          cnt_m++;
        end
        if (out_val && out_rdy) cnt_m--;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush && out_val && out_rdy) begin
      if (exp_q.size() == 0) chk("pop_on_empty", 1, 0);
      else chk("out_dat", int'(out_dat), int'(exp_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    out_rdy = 1'b1;
    in_val  = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (level == '0 && !out_val) break;
      step();
    end
    chk(name, int'(level), 0);
    out_rdy = 1'b0;
  endtask

  task automatic wait_out(input string name);
    for (int k = 0; k < 20; k++) begin
      if (out_val) break;
      step();
    end
    chk(name, int'(out_val), 1);
  endtask

  task automatic fill5_pend();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_dat = DW'(16'h0060 + i);
      step();
    end
    in_val = 1'b0;
    repeat (3) step();
    in_val  = 1'b1;
    in_dat  = 16'h0065;
    out_rdy = 1'b1;
    step();
    in_val  = 1'b0;
    out_rdy = 1'b0;
    chk("fill5_level", int'(level), 5);
  endtask

  initial begin
    int gaps;
    int acc;
    bit primed;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_out_dat", int'(out_dat), 0);
    chk("rst_in_rdy", int'(in_rdy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ram_w_a", int'(ram_w_a), 0);
    chk("ram_w_b", int'(ram_w_b), 0);
    rst = 1'b0;

    // Fill to capacity with no reads.
    in_val = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      in_dat = DW'(16'h0011 + i);
      step();
    end
    chk("t1_in_rdy_full", int'(in_rdy), 0);
    chk("t1_level_full", int'(level), CAP);
    in_dat = 16'h0019;
    step();
    chk("t1_ninth_rejected", int'(level), CAP);

    // Pop and write together while full: only the pop happens.
    out_rdy = 1'b1;
    chk("t4_in_rdy_with_pop", int'(in_rdy), 0);
    step();
    chk("t4_level_after_pop", int'(level), 7);
    chk("t4_in_rdy_reopen", int'(in_rdy), 1);
    out_rdy = 1'b0;
    step();
    chk("t4_level_refill", int'(level), CAP);
    in_val = 1'b0;
    drain("t4_drain");

    // First-word latency into an empty FIFO.
    in_val = 1'b1;
    in_dat = 16'hA5A5;
    step();
    in_val = 1'b0;
    chk("t2_val_n", int'(out_val), 0);
    chk("t2_level_n", int'(level), 1);
    step();
    chk("t2_val_n1", int'(out_val), 0);
    step();
    chk("t2_val_n2", int'(out_val), 1);
    chk("t2_dat_n2", int'(out_dat), 16'hA5A5);
    chk("t2_level_n2", int'(level), 1);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("t2_level_pop", int'(level), 0);
    chk("t2_val_pop", int'(out_val), 0);

    // Streaming through pointer wrap.
    gaps   = 0;
    primed = 1'b0;
    in_val  = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_dat = DW'(16'h0100 + i);
      step();
      if (out_val) primed = 1'b1;
      else if (primed) gaps++;
    end
    in_val = 1'b0;
    chk("t3_primed", int'(primed), 1);
    chk("t3_gaps", gaps, 0);
    drain("t3_drain");

    // Random traffic with output stalls.
    acc = 0;
    for (int cyc = 0; cyc < 3000 && acc < 200; cyc++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_dat  = DW'($urandom);
      out_rdy = 1'($urandom_range(0, 1));
      #2;
      if (in_val && in_rdy) acc++;
      @(posedge clk);
      #1;
    end
    chk("t5_words", acc, 200);
    drain("t5_drain");

    // Asynchronous reset with a read in flight.
    fill5_pend();
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_out_val", int'(out_val), 0);
    chk("t6_rst_level", int'(level), 0);
    chk("t6_rst_in_rdy", int'(in_rdy), 0);
    step();
    rst = 1'b0;
    in_val = 1'b1;
    in_dat = 16'hBEEF;
    step();
    in_val = 1'b0;
    wait_out("t6_rst_first_val");
    chk("t6_rst_first_dat", int'(out_dat), 16'hBEEF);
    chk("t6_rst_level1", int'(level), 1);
    drain("t6_rst_drain");

    // Synchronous flush with a read in flight and traffic offered.
    fill5_pend();
    flush   = 1'b1;
    in_val  = 1'b1;
    in_dat  = 16'hDEAD;
    out_rdy = 1'b1;
    #1;
    chk("t6_fl_in_rdy", int'(in_rdy), 0);
    chk("t6_fl_ram_w_a", int'(ram_w_a), 0);
    @(posedge clk);
    #1;
    flush   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    chk("t6_fl_out_val", int'(out_val), 0);
    chk("t6_fl_level", int'(level), 0);
    step();
    step();
    chk("t6_fl_no_leak", int'(out_val), 0);
    in_val = 1'b1;
    in_dat = 16'hCAFE;
    step();
    in_val = 1'b0;
    wait_out("t6_fl_first_val");
    chk("t6_fl_first_dat", int'(out_dat), 16'hCAFE);
    drain("t6_fl_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
